// File: rtl/bar_graph_pwm_wb_if.sv
// bar_graph_pwm_wb_if: Wishbone slave bus bundle for the LED bar-graph controller.
interface bar_graph_pwm_wb_if #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] wbs_address;
   logic [DATA_WIDTH-1:0] wbs_writedata;
   logic [DATA_WIDTH-1:0] wbs_readdata;
   logic                  wbs_strobe;
   logic                  wbs_write;
   logic                  wbs_cycle;
   logic                  wbs_ack;
   modport master (
      output wbs_address, wbs_writedata, wbs_strobe, wbs_write, wbs_cycle,
      input  wbs_readdata, wbs_ack
   );
   modport slave (
      input  wbs_address, wbs_writedata, wbs_strobe, wbs_write, wbs_cycle,
      output wbs_readdata, wbs_ack
   );
endinterface

// File: rtl/bar_graph_pwm_wb.sv
// bar_graph_pwm_wb: Wishbone LED bar-graph controller with display modes, tick prescaler and PWM brightness.
module bar_graph_pwm_wb #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 16,
   parameter int NUM_LEDS   = 8,
   parameter int PWM_BITS   = 8
) (
   input  logic                clk,
   input  logic                reset,
   output logic [NUM_LEDS-1:0] bar_graph,
   bar_graph_pwm_wb_if.slave   wbs
);
   logic [3:0]            ctrl_q, ctrl_d;
   logic [DATA_WIDTH-1:0] value_q, value_d;
   logic [PWM_BITS-1:0]   bright_q, bright_d;
   logic [DATA_WIDTH-1:0] period_q, period_d;
   logic [DATA_WIDTH-1:0] presc_q, presc_d;
   logic                  phase_q, phase_d;
   logic [NUM_LEDS-1:0]   scroll_q, scroll_d;
   logic [PWM_BITS-1:0]   cnt_q, cnt_d;
   logic [NUM_LEDS-1:0]   bar_q, bar_d;
   logic                  ack_q, ack_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  req, wr, wr_ctrl, wr_value, wr_bright, wr_period;
   logic                  tick, on, enter_scroll;
   logic [1:0]            mode;
   logic [NUM_LEDS-1:0]   therm, pat;
   logic [DATA_WIDTH-1:0] rmux;
   logic [DATA_WIDTH-1:0] wdata;
   logic [ADDR_WIDTH-1:0] addr;
   always_comb begin
      wdata     = wbs.wbs_writedata;
      addr      = wbs.wbs_address;
      req       = wbs.wbs_cycle & wbs.wbs_strobe & ~ack_q;
      wr        = req & wbs.wbs_write;
      wr_ctrl   = wr && addr == ADDR_WIDTH'(0);
      wr_value  = wr && addr == ADDR_WIDTH'(1);
      wr_bright = wr && addr == ADDR_WIDTH'(2);
      wr_period = wr && addr == ADDR_WIDTH'(3);
      mode      = ctrl_q[2:1];
      tick      = presc_q == period_q;
      // all-ones brightness must be fully on, which cnt < BRIGHT alone never reaches
      on        = (&bright_q) | (cnt_q < bright_q);
      therm     = '0;
      for (int i = 0; i < NUM_LEDS; i++) therm[i] = value_q > DATA_WIDTH'(i);
      pat = mode == 2'd0 ? value_q[NUM_LEDS-1:0] :
            mode == 2'd1 ? therm :
            mode == 2'd2 ? value_q[NUM_LEDS-1:0] & {NUM_LEDS{phase_q}} : scroll_q;
      enter_scroll = wr_ctrl && wdata[2:1] == 2'b11 && mode != 2'b11;
      rmux = addr == ADDR_WIDTH'(0) ? DATA_WIDTH'(ctrl_q) :
             addr == ADDR_WIDTH'(1) ? value_q :
             addr == ADDR_WIDTH'(2) ? DATA_WIDTH'(bright_q) :
             addr == ADDR_WIDTH'(3) ? period_q :
             addr == ADDR_WIDTH'(4) ? DATA_WIDTH'(pat) : '0;
   end
   always_comb begin
      ctrl_d   = wr_ctrl ? wdata[3:0] : ctrl_q;
      value_d  = wr_value ? wdata : value_q;
      bright_d = wr_bright ? wdata[PWM_BITS-1:0] : bright_q;
      period_d = wr_period ? wdata : period_q;
      presc_d  = (wr_period | tick) ? '0 : presc_q + DATA_WIDTH'(1);
      phase_d  = phase_q ^ tick;
      // a VALUE load beats a same-cycle rotate; the doubled vector gives a rotate-left that also works for one LED
      scroll_d = wr_value ? wdata[NUM_LEDS-1:0] :
                 enter_scroll ? value_q[NUM_LEDS-1:0] :
                 tick ? NUM_LEDS'({scroll_q, scroll_q} >> (NUM_LEDS - 1)) : scroll_q;
      cnt_d    = cnt_q + PWM_BITS'(1);
      bar_d    = ctrl_q[0] ? ((pat & {NUM_LEDS{on}}) ^ {NUM_LEDS{ctrl_q[3]}}) : '0;
      ack_d    = req;
      rdata_d  = (req & ~wbs.wbs_write) ? rmux : rdata_q;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         ctrl_q   <= '0;
         value_q  <= '0;
         bright_q <= '1;
         period_q <= '0;
         presc_q  <= '0;
         phase_q  <= 1'b1;
         scroll_q <= '0;
         cnt_q    <= '0;
         bar_q    <= '0;
         ack_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         ctrl_q   <= ctrl_d;
         value_q  <= value_d;
         bright_q <= bright_d;
         period_q <= period_d;
         presc_q  <= presc_d;
         phase_q  <= phase_d;
         scroll_q <= scroll_d;
         cnt_q    <= cnt_d;
         bar_q    <= bar_d;
         ack_q    <= ack_d;
         rdata_q  <= rdata_d;
      end
   end
   assign bar_graph        = bar_q;
   assign wbs.wbs_ack      = ack_q;
   assign wbs.wbs_readdata = rdata_q;
endmodule

// File: doc/bar_graph_pwm_wb.md
Name: bar_graph_pwm_wb

Overview:
- Wishbone-slave LED bar-graph controller, parametrised in LED count, bus width and PWM resolution.
- Adds a register file, display modes (direct, thermometer, blink, scroll), a programmable tick prescaler and global PWM brightness.
- Sits on the board-level Wishbone bus and drives the BeagleWire LED bank.

Parameters:
ADDR_WIDTH, 3, word-address width; registers 0..4 are decoded, higher addresses are unmapped.
DATA_WIDTH, 16, Wishbone data width; must be >= NUM_LEDS and >= PWM_BITS.
NUM_LEDS, 8, number of LED outputs (1..DATA_WIDTH).
PWM_BITS, 8, brightness counter/duty width.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
bar_graph  output  NUM_LEDS  LED drive, registered
wbs_address  input  ADDR_WIDTH  word address
wbs_writedata  input  DATA_WIDTH  write data
wbs_readdata  output  DATA_WIDTH  read data, registered
wbs_strobe  input  1  strobe
wbs_write  input  1  1 = write, 0 = read
wbs_cycle  input  1  bus cycle in progress
wbs_ack  output  1  single-cycle acknowledge, registered

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low (reset=0 on a clk edge).
- Reset values:
  - CTRL=0, VALUE=0, BRIGHT=all ones, PERIOD=0.
  - Prescaler=0, blink phase=1, scroll pattern=0, PWM counter=0.
  - bar_graph=0, wbs_ack=0, wbs_readdata=0.
  - Reset asserted mid-transaction drops ack and aborts any pending write.
- Register map (word addresses):
  - 0 CTRL: [0] EN, [2:1] MODE (00 direct, 01 thermometer, 10 blink, 11 scroll), [3] INV.
  - 1 VALUE: pattern or count.
  - 2 BRIGHT: [PWM_BITS-1:0].
  - 3 PERIOD: full width.
  - 4 STATUS: read-only, returns the current pre-PWM display pattern in [NUM_LEDS-1:0].
  - Unimplemented bits read 0. Unmapped addresses read 0 and writes there are ignored.
- Handshake:
  - A request is wbs_cycle & wbs_strobe & !wbs_ack.
  - wbs_ack asserts exactly one cycle after the request, for one cycle. It is never asserted on consecutive cycles, so a held strobe yields an ack every second cycle.
  - A write commits on the request edge.
  - Read data is captured on the request edge and is valid while ack=1. It holds its value otherwise.
- Prescaler:
  - Counts 0..PERIOD. On reaching PERIOD it emits a one-cycle tick and returns to 0, so there is one tick every PERIOD+1 cycles. PERIOD=0 gives a tick every cycle.
  - Any write to PERIOD clears the prescaler, so the first tick falls PERIOD+1 cycles after the write.
- Display pattern P, by mode:
  - direct: P = VALUE[NUM_LEDS-1:0].
  - thermometer: P = the min(VALUE, NUM_LEDS) lowest bits set. VALUE >= NUM_LEDS lights all LEDs; VALUE=0 lights none.
  - blink: P = VALUE masked by the blink phase. The phase toggles on each tick.
  - scroll:
    - The internal pattern S rotates left by one bit (MSB wraps to bit 0) on each tick; P = S.
    - Writing VALUE loads S. A VALUE write and a tick in the same cycle: the load wins.
    - Entering scroll mode through a CTRL write loads S from VALUE.
- PWM:
  - The PWM counter free-runs mod 2^PWM_BITS.
  - on = (cnt < BRIGHT), except that BRIGHT = all ones forces on=1. BRIGHT=0 forces off.
- Output: bar_graph <= EN ? ((P & {NUM_LEDS{on}}) ^ {NUM_LEDS{INV}}) : 0, registered, one cycle after P and on.
  - With EN=0 the output is all zero regardless of INV.
  - The prescaler and PWM counter keep running while EN=0.
- Width rules:
  - Writes take the low bits of each field; extra bits are ignored.
  - The thermometer comparison uses the full DATA_WIDTH VALUE, unsigned.

Test Plan:
- Reset: hold reset=0 for 3 cycles -> bar_graph=0, wbs_ack=0, a read of addr 2 returns 0x00FF, a read of addr 3 returns 0.
- Direct write: write CTRL=0x1, VALUE=0xA5 -> ack one cycle after each strobe, bar_graph=0xA5 within 2 cycles; a read of addr 1 returns 0x00A5; a read of addr 6 returns 0 and is still acked.
- Thermometer: CTRL=0x3, VALUE=3 -> 0x07; VALUE=8 -> 0xFF; VALUE=200 -> 0xFF; VALUE=0 -> 0x00. Repeat with CTRL=0xB (INV) and VALUE=3 -> 0xF8.
- Blink/scroll:
  - PERIOD=4, CTRL=0x5, VALUE=0x0F -> bar_graph alternates 0x0F/0x00 every 5 cycles.
  - CTRL=0x7, VALUE=0x81 -> sequence 0x81, 0x03, 0x06, … changing every 5 cycles.
  - Writing VALUE=0x01 mid-scroll restarts from 0x01.
- PWM: CTRL=0x1, VALUE=0xFF, BRIGHT=64 -> each LED high for 64 of every 256 cycles; BRIGHT=0 -> always 0; BRIGHT=255 -> always 0xFF.
- Handshake: hold cycle=strobe=1 with write=1 for 6 cycles -> ack pattern 0,1,0,1,0,1 and exactly 3 writes committed; assert reset=0 while ack=1 -> ack=0 next cycle and all registers return to reset values.
